// File: rtl/mu0_pkg.sv
// Shared definitions for the MU0 control unit: opcode values, controller state
// encoding, ALU function codes and the default memory-wait timeout.
package mu0_pkg;

  typedef enum logic [3:0] {
    OpLda = 4'h0,
    OpSta = 4'h1,
    OpAdd = 4'h2,
    OpSub = 4'h3,
    OpJmp = 4'h4,
    OpJge = 4'h5,
    OpJne = 4'h6,
    OpStp = 4'h7
  } opcode_e;

  typedef enum logic [1:0] {
    StFetch = 2'd0,
    StExec  = 2'd1,
    StHalt  = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    AluPass = 2'b00,
    AluAdd  = 2'b01,
    AluSub  = 2'b10
  } alu_fn_e;

  localparam int unsigned TimeoutDefault = 15;

endpackage

// File: rtl/mu0_control_if.sv
// Control/datapath/memory signal bundle of the MU0 control unit.
//   master: the controller (samples opcode, flags, mem_ready; drives strobes and status)
//   slave : datapath + memory side (the opposite directions)
interface mu0_control_if;
  logic [3:0] opcode;     // IR[15:12]
  logic       acc_n;      // accumulator negative
  logic       acc_z;      // accumulator zero
  logic       mem_ready;  // memory completes the current request
  logic       mem_req;
  logic       mem_we;
  logic       addr_sel;   // 0 = PC, 1 = IR[11:0]
  logic       pc_sel;     // 0 = PC+1, 1 = IR[11:0]
  logic       pc_ld;
  logic       ir_ld;
  logic       acc_ld;
  logic       acc_oe;
  logic [1:0] alu_fn;
  logic       halted;
  logic       bus_err;

  modport master (
    input  opcode, acc_n, acc_z, mem_ready,
    output mem_req, mem_we, addr_sel, pc_sel, pc_ld, ir_ld, acc_ld, acc_oe, alu_fn,
           halted, bus_err
  );

  modport slave (
    output opcode, acc_n, acc_z, mem_ready,
    input  mem_req, mem_we, addr_sel, pc_sel, pc_ld, ir_ld, acc_ld, acc_oe, alu_fn,
           halted, bus_err
  );
endinterface

// File: rtl/mu0_wait_timer.sv
// Counts consecutive cycles in which a memory request is pending without completion.
//   clk, reset : clock and synchronous active-high reset
//   active     : a memory request is being made this cycle
//   done       : memory completes the request this cycle
//   expired    : this cycle is the TIMEOUT-th consecutive unanswered request cycle
module mu0_wait_timer #(
  parameter int unsigned TIMEOUT = mu0_pkg::TimeoutDefault
) (
  input  logic clk,
  input  logic reset,
  input  logic active,
  input  logic done,
  output logic expired
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  logic [CntW-1:0] count_q, count_d;

  // Counter holds the number of earlier unanswered cycles, so the current
  // cycle is wait number count_q + 1.
  always_comb begin
    count_d = '0;
    if (active && !done) count_d = count_q + CntW'(1);
  end

  assign expired = active && !done && (count_q == CntW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

endmodule

// File: rtl/mu0_control.sv
// MU0 control unit: FETCH/EXEC/HALT sequencer with memory handshake and timeout.
//   clk, reset : clock and synchronous active-high reset
//   bus        : mu0_control_if master (opcode, flags, mem_ready in; strobes, status out)
// All outputs are decoded combinationally from state, opcode, flags and mem_ready.
module mu0_control
  import mu0_pkg::*;
#(
  parameter int unsigned TIMEOUT = TimeoutDefault
) (
  input  logic          clk,
  input  logic          reset,
  mu0_control_if.master bus
);

  state_e  state_q, state_d;
  logic    bus_err_q, bus_err_d;
  // High for the first cycle after reset; strobes and requests stay off then.
  logic    settle_q;
  logic    expired;

  logic    mem_req, mem_we, addr_sel, pc_sel, pc_ld, ir_ld, acc_ld, acc_oe;
  alu_fn_e alu_fn;

  mu0_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .clk     (clk),
    .reset   (reset),
    .active  (mem_req),
    .done    (bus.mem_ready),
    .expired (expired)
  );

  always_comb begin
    state_d   = state_q;
    bus_err_d = bus_err_q;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    addr_sel  = 1'b0;
    pc_sel    = 1'b0;
    pc_ld     = 1'b0;
    ir_ld     = 1'b0;
    acc_ld    = 1'b0;
    acc_oe    = 1'b0;
    alu_fn    = AluPass;

    if (!reset && !settle_q) begin
      unique case (state_q)
        StFetch: begin
          mem_req = 1'b1;
          if (bus.mem_ready) begin
            ir_ld   = 1'b1;
            pc_ld   = 1'b1;
            state_d = StExec;
          end
        end
        StExec: begin
          case (bus.opcode)
            OpLda, OpAdd, OpSub: begin
              addr_sel = 1'b1;
              mem_req  = 1'b1;
              alu_fn   = (bus.opcode == OpAdd) ? AluAdd :
                         (bus.opcode == OpSub) ? AluSub : AluPass;
              if (bus.mem_ready) begin
                acc_ld  = 1'b1;
                state_d = StFetch;
              end
            end
            OpSta: begin
              addr_sel = 1'b1;
              mem_req  = 1'b1;
              mem_we   = 1'b1;
              acc_oe   = 1'b1;
              if (bus.mem_ready) state_d = StFetch;
            end
            OpJmp: begin
              pc_ld   = 1'b1;
              pc_sel  = 1'b1;
              state_d = StFetch;
            end
            OpJge: begin
              pc_ld   = !bus.acc_n;
              pc_sel  = !bus.acc_n;
              state_d = StFetch;
            end
            OpJne: begin
              pc_ld   = !bus.acc_z;
              pc_sel  = !bus.acc_z;
              state_d = StFetch;
            end
            // STP and every illegal opcode stop the machine without an error.
            default: state_d = StHalt;
          endcase
        end
        StHalt:  ;
        default: state_d = StFetch;
      endcase

      // Expiry only occurs while waiting, so no strobe is active this cycle.
      if (expired) begin
        state_d   = StHalt;
        bus_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StFetch;
      bus_err_q <= 1'b0;
      settle_q  <= 1'b1;
    end else begin
      state_q   <= state_d;
      bus_err_q <= bus_err_d;
      settle_q  <= 1'b0;
    end
  end

  assign bus.mem_req  = mem_req;
  assign bus.mem_we   = mem_we;
  assign bus.addr_sel = addr_sel;
  assign bus.pc_sel   = pc_sel;
  assign bus.pc_ld    = pc_ld;
  assign bus.ir_ld    = ir_ld;
  assign bus.acc_ld   = acc_ld;
  assign bus.acc_oe   = acc_oe;
  assign bus.alu_fn   = alu_fn;
  assign bus.halted   = (state_q == StHalt);
  assign bus.bus_err  = bus_err_q;

endmodule

// File: tb/tb_mu0_control.sv
// Self-checking bench for mu0_control against an instruction-level reference model.
module tb_mu0_control;

  localparam int unsigned TIMEOUT = 15;

  logic clk = 1'b0;
  logic reset;
  mu0_control_if bus ();

  mu0_control #(
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // Reference model: phase 0 = fetching, 1 = executing, 2 = stopped.
  int   m_phase;
  bit   m_settle;
  int   m_waits;
  bit   m_err;
  bit   m_req;

  // {mem_req, mem_we, addr_sel, pc_sel, pc_ld, ir_ld, acc_ld, acc_oe, alu_fn[1:0], halted, bus_err}
  logic [11:0] exp_v, msk_v, obs_v;

  function automatic void model_out();
    logic [3:0] op;
    op    = bus.opcode;
    exp_v = '0;
    msk_v = '1;
    m_req = 1'b0;
    exp_v[1] = (m_phase == 2);
    exp_v[0] = m_err;
    if (reset || m_settle) return;
    if (m_phase == 0) begin
      m_req = 1'b1;
      if (bus.mem_ready) exp_v[7:6] = 2'b11;
    end else if (m_phase == 1) begin
      case (op)
        4'h0, 4'h2, 4'h3: begin
          m_req    = 1'b1;
          exp_v[9] = 1'b1;
          if (bus.mem_ready) begin
            exp_v[5]   = 1'b1;
            exp_v[3:2] = (op == 4'h0) ? 2'b00 : (op == 4'h2) ? 2'b01 : 2'b10;
          end
        end
        4'h1: begin
          m_req    = 1'b1;
          exp_v[10] = 1'b1;
          exp_v[9]  = 1'b1;
          exp_v[4]  = 1'b1;
        end
        4'h4: exp_v[8:7] = 2'b11;
        4'h5: if (!bus.acc_n) exp_v[8:7] = 2'b11;
        4'h6: if (!bus.acc_z) exp_v[8:7] = 2'b11;
        default: ;
      endcase
    end
    exp_v[11] = m_req;
    if (!exp_v[5]) msk_v[3:2] = 2'b00;
    if (!exp_v[7]) msk_v[8]   = 1'b0;
  endfunction

  function automatic void model_update();
    if (reset) begin
      m_phase = 0; m_waits = 0; m_err = 1'b0; m_settle = 1'b1;
      return;
    end
    if (m_settle) begin
      m_settle = 1'b0;
      return;
    end
    if (m_phase == 2) return;
    if (m_req) begin
      if (bus.mem_ready) begin
        m_waits = 0;
        m_phase = (m_phase == 0) ? 1 : 0;
      end else begin
        m_waits++;
        if (m_waits == TIMEOUT) begin
          m_phase = 2; m_err = 1'b1; m_waits = 0;
        end
      end
    end else begin
      m_waits = 0;
      m_phase = (bus.opcode >= 4'h7) ? 2 : 0;
    end
  endfunction

  task automatic eval_cycle();
    @(negedge clk);
    model_out();
    obs_v = {bus.mem_req, bus.mem_we, bus.addr_sel, bus.pc_sel, bus.pc_ld, bus.ir_ld,
             bus.acc_ld, bus.acc_oe, bus.alu_fn, bus.halted, bus.bus_err};
  endtask

  task automatic adv();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [3:0] op, input logic n, input logic z, input logic rdy);
    bus.opcode = op; bus.acc_n = n; bus.acc_z = z; bus.mem_ready = rdy;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    model_out();
    adv();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_in(4'($urandom), 1'($urandom), 1'($urandom), 1'b1);
      if (i == 3) reset = 1'b0;  // settle cycle right after reset
      eval_cycle();
      n_checks++;
      if ((obs_v & msk_v) !== (exp_v & msk_v)) begin
        n_err++;
        $display("FAIL reset cyc%0d: got %b want %b", i, obs_v & msk_v, exp_v & msk_v);
      end
      n_checks++;
      if (obs_v[11:4] !== 8'h00) begin
        n_err++;
        $display("FAIL reset_strobes cyc%0d: got %b want 00000000", i, obs_v[11:4]);
      end
      adv();
    end
  endtask

  task automatic test_lda();
    do_reset();
    set_in(4'h0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) begin
      eval_cycle();
      n_checks++;
      if ((obs_v & msk_v) !== (exp_v & msk_v)) begin
        n_err++;
        $display("FAIL lda cyc%0d: got %b want %b", i, obs_v & msk_v, exp_v & msk_v);
      end
      if (i == 1) begin
        n_checks++;
        if ({bus.ir_ld, bus.pc_ld, bus.pc_sel} !== 3'b110) begin
          n_err++;
          $display("FAIL lda_fetch: got %b want 110", {bus.ir_ld, bus.pc_ld, bus.pc_sel});
        end
      end
      if (i == 2) begin
        n_checks++;
        if ({bus.addr_sel, bus.acc_ld, bus.alu_fn} !== 4'b1100) begin
          n_err++;
          $display("FAIL lda_exec: got %b want 1100", {bus.addr_sel, bus.acc_ld, bus.alu_fn});
        end
      end
      adv();
    end
  endtask

  task automatic test_jumps();
    logic [3:0] ops [5]  = '{4'h5, 4'h5, 4'h6, 4'h6, 4'h4};
    logic       ns  [5]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic       zs  [5]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic       ld  [5]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    do_reset();
    set_in(4'h4, 1'b0, 1'b0, 1'b1);
    eval_cycle();
    adv();  // settle
    for (int r = 0; r < 5; r++) begin
      set_in(ops[r], ns[r], zs[r], 1'b1);
      for (int c = 0; c < 2; c++) begin
        eval_cycle();
        n_checks++;
        if ((obs_v & msk_v) !== (exp_v & msk_v)) begin
          n_err++;
          $display("FAIL jump r%0d c%0d: got %b want %b", r, c, obs_v & msk_v, exp_v & msk_v);
        end
        if (c == 1) begin
          n_checks++;
          if (bus.pc_ld !== ld[r] || (ld[r] && bus.pc_sel !== 1'b1) || bus.mem_req !== 1'b0) begin
            n_err++;
            $display("FAIL jump_exec r%0d: pc_ld %b pc_sel %b mem_req %b want pc_ld %b",
                     r, bus.pc_ld, bus.pc_sel, bus.mem_req, ld[r]);
          end
        end
        adv();
      end
    end
  endtask

  task automatic test_sta_wait();
    logic rdy [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    do_reset();
    set_in(4'h1, 1'b0, 1'b0, 1'b0);
    eval_cycle();
    adv();  // settle
    for (int i = 0; i < 6; i++) begin
      bus.mem_ready = rdy[i];
      eval_cycle();
      n_checks++;
      if ((obs_v & msk_v) !== (exp_v & msk_v)) begin
        n_err++;
        $display("FAIL sta cyc%0d: got %b want %b", i, obs_v & msk_v, exp_v & msk_v);
      end
      if (i >= 1 && i <= 4) begin
        n_checks++;
        if ({bus.mem_req, bus.mem_we, bus.acc_oe, bus.addr_sel, bus.ir_ld, bus.pc_ld,
             bus.acc_ld} !== 7'b1111000) begin
          n_err++;
          $display("FAIL sta_hold cyc%0d: got %b want 1111000", i,
                   {bus.mem_req, bus.mem_we, bus.acc_oe, bus.addr_sel, bus.ir_ld, bus.pc_ld,
                    bus.acc_ld});
        end
      end
      if (i == 5) begin
        n_checks++;
        if ({bus.mem_req, bus.mem_we, bus.addr_sel} !== 3'b100) begin
          n_err++;
          $display("FAIL sta_next_fetch: got %b want 100", {bus.mem_req, bus.mem_we, bus.addr_sel});
        end
      end
      adv();
    end
  endtask

  task automatic test_timeout();
    do_reset();
    set_in(4'h0, 1'b0, 1'b0, 1'b0);
    eval_cycle();
    adv();  // settle
    for (int i = 1; i <= 19; i++) begin
      eval_cycle();
      n_checks++;
      if ((obs_v & msk_v) !== (exp_v & msk_v)) begin
        n_err++;
        $display("FAIL timeout cyc%0d: got %b want %b", i, obs_v & msk_v, exp_v & msk_v);
      end
      if (i == 15) begin
        n_checks++;
        if ({bus.mem_req, bus.halted, bus.bus_err} !== 3'b100) begin
          n_err++;
          $display("FAIL timeout_last_wait: got %b want 100", {bus.mem_req, bus.halted, bus.bus_err});
        end
      end
      if (i >= 16) begin
        n_checks++;
        if ({bus.mem_req, bus.halted, bus.bus_err, bus.ir_ld} !== 4'b0110) begin
          n_err++;
          $display("FAIL timeout_halt cyc%0d: got %b want 0110", i,
                   {bus.mem_req, bus.halted, bus.bus_err, bus.ir_ld});
        end
      end
      if (i == 17) bus.mem_ready = 1'b1;  // must be ignored while halted
      adv();
    end
  endtask

  task automatic test_stop();
    logic [3:0] ops [2] = '{4'h7, 4'hC};
    for (int r = 0; r < 2; r++) begin
      do_reset();
      set_in(ops[r], 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 5; i++) begin
        eval_cycle();
        n_checks++;
        if ((obs_v & msk_v) !== (exp_v & msk_v)) begin
          n_err++;
          $display("FAIL stop op%h cyc%0d: got %b want %b", ops[r], i, obs_v & msk_v,
                   exp_v & msk_v);
        end
        if (i >= 3) begin
          n_checks++;
          if ({bus.halted, bus.bus_err, bus.mem_req, bus.pc_ld, bus.acc_ld} !== 5'b10000) begin
            n_err++;
            $display("FAIL stop_halt op%h: got %b want 10000", ops[r],
                     {bus.halted, bus.bus_err, bus.mem_req, bus.pc_ld, bus.acc_ld});
          end
        end
        adv();
      end
      do_reset();
      eval_cycle();
      adv();  // settle
      eval_cycle();
      n_checks++;
      if ({bus.halted, bus.mem_req, bus.addr_sel} !== 3'b010) begin
        n_err++;
        $display("FAIL stop_rereset op%h: got %b want 010", ops[r],
                 {bus.halted, bus.mem_req, bus.addr_sel});
      end
      adv();
    end
  endtask

  task automatic test_reset_mid_add();
    bit acc_seen = 1'b0;
    do_reset();
    set_in(4'h2, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 7; i++) begin
      bus.mem_ready = (i == 1) || (i == 4);
      reset = (i == 4);
      eval_cycle();
      acc_seen |= bus.acc_ld;
      n_checks++;
      if ((obs_v & msk_v) !== (exp_v & msk_v)) begin
        n_err++;
        $display("FAIL midadd cyc%0d: got %b want %b", i, obs_v & msk_v, exp_v & msk_v);
      end
      if (i == 4) begin
        n_checks++;
        if (bus.mem_req !== 1'b0) begin
          n_err++;
          $display("FAIL midadd_reset_req: got %b want 0", bus.mem_req);
        end
      end
      if (i == 6) begin
        n_checks++;
        if ({bus.mem_req, bus.addr_sel, bus.mem_we} !== 3'b100) begin
          n_err++;
          $display("FAIL midadd_fetch: got %b want 100", {bus.mem_req, bus.addr_sel, bus.mem_we});
        end
      end
      adv();
    end
    reset = 1'b0;
    n_checks++;
    if (acc_seen !== 1'b0) begin
      n_err++;
      $display("FAIL midadd_acc_ld: got 1 want 0");
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 99) < 2) || (m_phase == 2 && $urandom_range(0, 7) == 0);
      if (m_phase != 1) begin
        if ($urandom_range(0, 99) < 85) bus.opcode = 4'($urandom_range(0, 6));
        else                            bus.opcode = 4'($urandom_range(7, 15));
      end
      bus.acc_n     = 1'($urandom);
      bus.acc_z     = 1'($urandom);
      bus.mem_ready = ((i % 500) < 20) ? 1'b0 : ($urandom_range(0, 3) != 0);
      eval_cycle();
      n_checks++;
      if ((obs_v & msk_v) !== (exp_v & msk_v)) begin
        n_err++;
        $display("FAIL random cyc%0d op%h rdy%b rst%b: got %b want %b", i, bus.opcode,
                 bus.mem_ready, reset, obs_v & msk_v, exp_v & msk_v);
      end
      adv();
    end
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    set_in(4'h0, 1'b0, 1'b0, 1'b0);
    m_phase = 0; m_settle = 1'b1; m_waits = 0; m_err = 1'b0; m_req = 1'b0;
    @(posedge clk);
    #1;
    model_update();
    test_reset();
    test_lda();
    test_jumps();
    test_sta_wait();
    test_timeout();
    test_stop();
    test_reset_mid_add();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
